dmem_responder: RTL and testbench

- Memory-side responder for the CPU's data-memory port. It accepts one load/store request at a time over a valid/ready handshake and inserts a configurable number of wait states.
- It performs the word access with byte enables, then returns read data and an error flag over a valid/ready response channel.
- It sits between the CPU load/store path (the initiator) and the on-chip data RAM. It replaces the zero-wait combinational data-memory model for multi-cycle timing studies.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_array.sv | 31 +++
 rtl/dmem_responder.sv | 118 +++++++++++
 tb/tb_dmem_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

    // Expand per-byte enables into a 32-bit bit mask.
    function automatic logic [31:0] be_to_mask(input logic [WORD_BYTES-1:0] be);
        logic [31:0] m;
        m = '0;
        for (int n = 0; n < WORD_BYTES; n++) begin
            m[8*n +: 8] = {8{be[n]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide data RAM with per-byte write enables and a registered read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int IDX_W       = 7
) (
    input  logic                  clk_i,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      idx,
    input  logic [31:0]           wdata,
    input  logic [WORD_BYTES-1:0] be,
    output logic [31:0]           rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] mask;

    assign mask = be_to_mask(be);

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[idx] <= (mem[idx] & ~mask) | (wdata & mask);
        end
        if (rd_en) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, LATENCY wait states, then a held response.
//
// state | meaning
// IDLE  | ready for a request; request fields captured on acceptance
// BUSY  | counting wait states; access performed when the counter reaches zero
// RESP  | response valid and held until rsp_ready_i
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] ADDR_LIMIT = 32'(WORD_BYTES * DEPTH_WORDS);
    localparam logic [3:0]  LAT_INIT   = 4'(LATENCY);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        req_write_q;
    logic [31:0] req_addr_q;
    logic [31:0] req_wdata_q;
    logic [3:0]  req_be_q;
    logic        rdata_ok;

    logic        acc_err;
    logic        acc_now;
    logic [31:0] arr_rdata;

    assign acc_err = (req_addr_q[1:0] != 2'b00) || (req_addr_q >= ADDR_LIMIT);
    assign acc_now = (state == BUSY) && (wait_cnt == 4'd0);

    // The RAM read register has no reset, so load data is gated by a reset flop.
    assign rsp_rdata_o = rdata_ok ? arr_rdata : 32'd0;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk_i (clk_i),
        .wr_en (acc_now && req_write_q && !acc_err),
        .rd_en (acc_now && !req_write_q && !acc_err),
        .idx   (req_addr_q[IDX_W+1:2]),
        .wdata (req_wdata_q),
        .be    (req_be_q),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rdata_ok    <= 1'b0;
            wait_cnt    <= 4'd0;
            req_write_q <= 1'b0;
            req_addr_q  <= 32'd0;
            req_wdata_q <= 32'd0;
            req_be_q    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        req_write_q <= req_write_i;
                        req_addr_q  <= req_addr_i;
                        req_wdata_q <= req_wdata_i;
                        req_be_q    <= req_be_i;
                        wait_cnt    <= LAT_INIT;
                        req_ready_o <= 1'b0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= acc_err;
                        rdata_ok    <= !req_write_q && !acc_err;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        rsp_err_o   <= 1'b0;
                        rdata_ok    <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_o <= 1'b0;
                    rsp_err_o   <= 1'b0;
                    rdata_ok    <= 1'b0;
                    req_ready_o <= 1'b1;
                    wait_cnt    <= 4'd0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 main instance plus a LATENCY=0 instance.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid_z, req_ready_z, req_write_z;
    logic [31:0] req_addr_z, req_wdata_z;
    logic [3:0]  req_be_z;
    logic        rsp_valid_z, rsp_ready_z, rsp_err_z;
    logic [31:0] rsp_rdata_z;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_be_i    (req_be),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(0)) dut0 (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid_z),
        .req_ready_o (req_ready_z),
        .req_write_i (req_write_z),
        .req_addr_i  (req_addr_z),
        .req_wdata_i (req_wdata_z),
        .req_be_i    (req_be_z),
        .rsp_valid_o (rsp_valid_z),
        .rsp_ready_i (rsp_ready_z),
        .rsp_rdata_o (rsp_rdata_z),
        .rsp_err_o   (rsp_err_z)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction on the LATENCY=2 instance; inputs are scrambled after acceptance.
    task automatic txn(input string tag, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       output logic [31:0] rd, output logic er);
        int n;
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = 32'h0000_0004;
        req_wdata = 32'hA5A5_5A5A;
        req_be    = 4'hF;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'd3);
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, " valid drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, " rdata clear"}, rsp_rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          n;

        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        rsp_ready = 1'b0;
        req_valid_z = 1'b0; req_write_z = 1'b0; req_addr_z = '0; req_wdata_z = '0; req_be_z = '0;
        rsp_ready_z = 1'b0;
        #12;
        chk("reset ready", 32'(req_ready), 32'd1);
        chk("reset valid", 32'(rsp_valid), 32'd0);
        chk("reset rdata", rsp_rdata, 32'd0);
        chk("reset err", 32'(rsp_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        txn("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, rd, er);
        chk("st10 rdata", rd, 32'd0);
        chk("st10 err", 32'(er), 32'd0);
        txn("ld10", 1'b0, 32'h10, 32'h0, 4'b0000, rd, er);
        chk("ld10 rdata", rd, 32'hDEAD_BEEF);
        chk("ld10 err", 32'(er), 32'd0);

        txn("st10p", 1'b1, 32'h10, 32'h0000_00AA, 4'b0001, rd, er);
        txn("ld10p", 1'b0, 32'h10, 32'h0, 4'b0000, rd, er);
        chk("ld10p rdata", rd, 32'hDEAD_BEAA);

        txn("ld12", 1'b0, 32'h12, 32'h0, 4'b1111, rd, er);
        chk("ld12 rdata", rd, 32'd0);
        chk("ld12 err", 32'(er), 32'd1);
        txn("ld200", 1'b0, 32'h200, 32'h0, 4'b1111, rd, er);
        chk("ld200 rdata", rd, 32'd0);
        chk("ld200 err", 32'(er), 32'd1);

        txn("st0", 1'b1, 32'h0, 32'h1111_1111, 4'b1111, rd, er);
        txn("st1fc", 1'b1, 32'h1FC, 32'h7F7F_7F7F, 4'b1111, rd, er);
        txn("st200", 1'b1, 32'h200, 32'hFFFF_FFFF, 4'b1111, rd, er);
        chk("st200 err", 32'(er), 32'd1);
        txn("st1fc be0", 1'b1, 32'h1FC, 32'h0000_0000, 4'b0000, rd, er);
        chk("st1fc be0 err", 32'(er), 32'd0);
        txn("ld0", 1'b0, 32'h0, 32'h0, 4'b0000, rd, er);
        chk("ld0 rdata", rd, 32'h1111_1111);
        txn("ld1fc", 1'b0, 32'h1FC, 32'h0, 4'b0000, rd, er);
        chk("ld1fc rdata", rd, 32'h7F7F_7F7F);

        // Response backpressure with a request waiting behind it.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_be = 4'hF;
        @(posedge clk); #1;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold latency", 32'(n), 32'd3);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("hold valid", 32'(rsp_valid), 32'd1);
            chk("hold rdata", rsp_rdata, 32'hDEAD_BEAA);
            chk("hold ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("hold handshake valid", 32'(rsp_valid), 32'd0);
        chk("hold handshake ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("hold second accept", 32'(req_ready), 32'd0);
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("second latency", 32'(n), 32'd3);
        chk("second rdata", rsp_rdata, 32'hDEAD_BEAA);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Reset while a store is waiting in BUSY.
        txn("st20 zero", 1'b1, 32'h20, 32'h0, 4'b1111, rd, er);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("busy ready", 32'(req_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst ready", 32'(req_ready), 32'd1);
        chk("async rst valid", 32'(rsp_valid), 32'd0);
        chk("async rst rdata", rsp_rdata, 32'd0);
        chk("async rst err", 32'(rsp_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        txn("ld20", 1'b0, 32'h20, 32'h0, 4'b0000, rd, er);
        chk("ld20 rdata", rd, 32'h0);

        // LATENCY=0: continuous requests and ready give a 3-cycle period.
        req_valid_z = 1'b1; req_write_z = 1'b0; req_addr_z = 32'h0; req_be_z = 4'hF;
        rsp_ready_z = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            chk("lat0 valid", 32'(rsp_valid_z), 32'((k % 3) == 1));
            chk("lat0 ready", 32'(req_ready_z), 32'((k % 3) == 2));
        end
        req_valid_z = 1'b0;
        rsp_ready_z = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
